// File: rtl/vga_fb_arbiter_pkg.sv
// rtl/vga_fb_arbiter_pkg.sv - framebuffer arbiter types and defaults
package vga_fb_arbiter_pkg;

  localparam int PPW_DEFAULT = 4;
  localparam int BPP_DEFAULT = 8;
  localparam int AW_DEFAULT  = 17;

  // Which requester owns the RAM port in the current cycle.
  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_SCAN,
    SRC_HOST_RD,
    SRC_HOST_WR
  } mem_src_e;

  function automatic int words_per_line(input int hsize, input int ppw);
    return hsize / ppw;
  endfunction

endpackage

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 video timing constants
package vga_timing_pkg;

  localparam int HSIZE = 640;
  localparam int HFP   = 16;
  localparam int HSP   = 96;
  localparam int HMAX  = 800;
  localparam int VSIZE = 480;
  localparam int VFP   = 10;
  localparam int VSP   = 2;
  localparam int VMAX  = 525;
  localparam bit HSPP  = 1'b0;
  localparam bit VSPP  = 1'b0;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - host request/response port of the framebuffer arbiter
interface vga_fb_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 32
);

  logic          valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/vga_pix_shift.sv
// rtl/vga_pix_shift.sv - scanout word shifter with 2-stage sync/blank delay
// Pixels leave LSB first; blanked pixels are forced to zero.
module vga_pix_shift #(
  parameter int PPW  = 4,
  parameter int BPP  = 8,
  parameter bit HSPP = 1'b0,
  parameter bit VSPP = 1'b0,
  localparam int DW  = PPW * BPP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [DW-1:0]  rdata,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           blank,
  output logic [BPP-1:0] pix_data,
  output logic           pix_hsync,
  output logic           pix_vsync,
  output logic           pix_blank
);

  logic [DW-1:0] sr;
  logic [1:0]    hs_d;
  logic [1:0]    vs_d;
  logic [1:0]    bl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      hs_d <= {2{~HSPP}};
      vs_d <= {2{~VSPP}};
      bl_d <= 2'b11;
    end else begin
      sr   <= load ? rdata : (sr >> BPP);
      hs_d <= {hs_d[0], hsync};
      vs_d <= {vs_d[0], vsync};
      bl_d <= {bl_d[0], blank};
    end
  end

  assign pix_hsync = hs_d[1];
  assign pix_vsync = vs_d[1];
  assign pix_blank = bl_d[1];
  assign pix_data  = pix_blank ? '0 : sr[BPP-1:0];

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer RAM shared by scanout and host
// Scanout owns every PPW-th visible column; the host gets all remaining cycles.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int HSIZE = vga_timing_pkg::HSIZE,
  parameter int HMAX  = vga_timing_pkg::HMAX,
  parameter int VSIZE = vga_timing_pkg::VSIZE,
  parameter int VMAX  = vga_timing_pkg::VMAX,
  parameter bit HSPP  = vga_timing_pkg::HSPP,
  parameter bit VSPP  = vga_timing_pkg::VSPP,
  parameter int PPW   = PPW_DEFAULT,
  parameter int BPP   = BPP_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  localparam int DW   = PPW * BPP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  hdata,
  input  logic [WIDTH-1:0]  vdata,
  input  logic              blank,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [AW-1:0]     fb_base,
  input  logic              fb_base_wr,
  vga_fb_arbiter_if.slave   host,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [BPP-1:0]    pix_data,
  output logic              pix_hsync,
  output logic              pix_vsync,
  output logic              pix_blank
);

  localparam int WPL = words_per_line(HSIZE, PPW);

  logic [AW-1:0] base_pending;
  logic [AW-1:0] line_addr;
  logic [AW-1:0] scan_addr;
  logic          scan_slot;
  logic          scan_pend;
  logic          rd_pend;
  mem_src_e      src;

  assign scan_slot  = !blank && ((hdata % WIDTH'(PPW)) == '0);
  assign scan_addr  = line_addr + AW'(hdata / WIDTH'(PPW));
  assign host.ready = !scan_slot;

  always_comb begin
    src = SRC_IDLE;
    if (scan_slot) begin
      src = SRC_SCAN;
    end else if (host.valid) begin
      src = host.we ? SRC_HOST_WR : SRC_HOST_RD;
    end
  end

  assign mem_en    = (src != SRC_IDLE);
  assign mem_we    = (src == SRC_HOST_WR);
  assign mem_addr  = (src == SRC_SCAN) ? scan_addr : host.addr;
  assign mem_wdata = host.wdata;

  // Read return: RAM data is valid one cycle after the access, then registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend     <= 1'b0;
      scan_pend   <= 1'b0;
      host.rvalid <= 1'b0;
      host.rdata  <= '0;
    end else begin
      rd_pend     <= (src == SRC_HOST_RD);
      scan_pend   <= (src == SRC_SCAN);
      host.rvalid <= rd_pend;
      if (rd_pend) begin
        host.rdata <= mem_rdata;
      end
    end
  end

  // The pending base is only copied into the line pointer at frame end, so a
  // write coinciding with frame end takes effect one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_pending <= '0;
      line_addr    <= '0;
    end else begin
      if (fb_base_wr) begin
        base_pending <= fb_base;
      end
      if (hdata == WIDTH'(HMAX - 1)) begin
        if (vdata == WIDTH'(VMAX - 1)) begin
          line_addr <= base_pending;
        end else if (vdata < WIDTH'(VSIZE)) begin
          line_addr <= line_addr + AW'(WPL);
        end
      end
    end
  end

  vga_pix_shift #(
    .PPW  (PPW),
    .BPP  (BPP),
    .HSPP (HSPP),
    .VSPP (VSPP)
  ) u_pix_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (scan_pend),
    .rdata     (mem_rdata),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .pix_data  (pix_data),
    .pix_hsync (pix_hsync),
    .pix_vsync (pix_vsync),
    .pix_blank (pix_blank)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [10:0] hdata;
  logic [10:0] vdata;
  logic        blank;
  logic        hsync;
  logic        vsync;
  logic [16:0] fb_base;
  logic        fb_base_wr;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  pix_data;
  logic        pix_hsync;
  logic        pix_vsync;
  logic        pix_blank;

  int n_tests = 0;
  int n_fail  = 0;

  vga_fb_arbiter_if #(.AW(17), .DW(32)) hif ();

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hdata      (hdata),
    .vdata      (vdata),
    .blank      (blank),
    .hsync      (hsync),
    .vsync      (vsync),
    .fb_base    (fb_base),
    .fb_base_wr (fb_base_wr),
    .host       (hif),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_data   (pix_data),
    .pix_hsync  (pix_hsync),
    .pix_vsync  (pix_vsync),
    .pix_blank  (pix_blank)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] ram [0:131071];
  logic        preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      ram[17'h00100] <= 32'h44332211;
      ram[17'h00101] <= 32'h88776655;
      ram[17'h00010] <= 32'hDEADBEEF;
      ram[17'h00000] <= 32'hA4A3A2A1;
      preloaded      <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_tg(input int h, input int v);
    hdata = 11'(h);
    vdata = 11'(v);
    blank = (h >= 640) || (v >= 480);
    hsync = !((h >= 656) && (h < 752));
    vsync = !((v >= 490) && (v < 492));
  endtask

  task automatic adv(input int h, input int v);
    @(posedge clk);
    #1;
    set_tg(h, v);
  endtask

  logic hs_q [0:99];
  logic vs_q [0:99];
  logic bl_q [0:99];

  initial begin
    int scan_ok;
    rst_n      = 1'b0;
    fb_base    = '0;
    fb_base_wr = 1'b0;
    hif.valid  = 1'b0;
    hif.we     = 1'b0;
    hif.addr   = '0;
    hif.wdata  = '0;
    set_tg(700, 10);

    // Reset mid-line, blanked region
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", 32'(hif.rvalid), 32'd0);
    chk("rst_rdata", hif.rdata, 32'd0);
    chk("rst_pix", 32'(pix_data), 32'd0);
    chk("rst_blank", 32'(pix_blank), 32'd1);
    chk("rst_hsync", 32'(pix_hsync), 32'd1);
    chk("rst_vsync", 32'(pix_vsync), 32'd1);
    adv(701, 10);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_mem_en", 32'(mem_en), 32'd0);
    chk("rel_ready", 32'(hif.ready), 32'd1);
    chk("rel_blank", 32'(pix_blank), 32'd1);

    // Base 0x100 latched, swapped in at frame end
    adv(702, 10);
    fb_base = 17'h00100; fb_base_wr = 1'b1;
    adv(799, 524);
    fb_base_wr = 1'b0;
    adv(0, 0);
    @(negedge clk);
    chk("t2_addr", 32'(mem_addr), 32'h100);
    chk("t2_en", 32'(mem_en), 32'd1);
    chk("t2_we", 32'(mem_we), 32'd0);
    chk("t2_ready", 32'(hif.ready), 32'd0);
    adv(1, 0);
    adv(2, 0); @(negedge clk);
    chk("t2_pix0", 32'(pix_data), 32'h11);
    chk("t2_pblank", 32'(pix_blank), 32'd0);
    adv(3, 0); @(negedge clk);
    chk("t2_pix1", 32'(pix_data), 32'h22);
    adv(4, 0); @(negedge clk);
    chk("t2_pix2", 32'(pix_data), 32'h33);
    chk("t2_addr4", 32'(mem_addr), 32'h101);
    adv(5, 0); @(negedge clk);
    chk("t2_pix3", 32'(pix_data), 32'h44);
    adv(6, 0); @(negedge clk);
    chk("t2_pix4", 32'(pix_data), 32'h55);
    adv(799, 0);

    // Full line 1 with a host write stalled by the slot at hdata=4
    scan_ok = 0;
    for (int h = 0; h < 800; h++) begin
      adv(h, 1);
      if (h == 4) begin
        hif.valid = 1'b1; hif.we = 1'b1;
        hif.addr = 17'h00050; hif.wdata = 32'hCAFEF00D;
      end else if (h == 6) begin
        hif.valid = 1'b0; hif.we = 1'b0;
      end
      @(negedge clk);
      if (h == 4) chk("t3_stall", 32'(hif.ready), 32'd0);
      if (h == 5) begin
        chk("t3_ready", 32'(hif.ready), 32'd1);
        chk("t3_we", 32'(mem_we), 32'd1);
        chk("t3_waddr", 32'(mem_addr), 32'h50);
      end
      if (h < 640 && (h % 4) == 0 && mem_en && !mem_we &&
          mem_addr == 17'(32'h1A0 + h / 4))
        scan_ok++;
    end
    chk("t3_scan_cnt", 32'(scan_ok), 32'd160);
    chk("t3_ram", ram[17'h00050], 32'hCAFEF00D);

    // Host read during blank
    adv(700, 2);
    hif.valid = 1'b1; hif.we = 1'b0; hif.addr = 17'h00010;
    @(negedge clk);
    chk("t4_ready", 32'(hif.ready), 32'd1);
    chk("t4_addr", 32'(mem_addr), 32'h10);
    adv(701, 2);
    hif.valid = 1'b0;
    @(negedge clk);
    chk("t4_rv_t1", 32'(hif.rvalid), 32'd0);
    adv(702, 2); @(negedge clk);
    chk("t4_rv_t2", 32'(hif.rvalid), 32'd1);
    chk("t4_rdata", hif.rdata, 32'hDEADBEEF);
    chk("t4_idle", 32'(mem_en), 32'd0);
    adv(703, 2); @(negedge clk);
    chk("t4_rv_t3", 32'(hif.rvalid), 32'd0);
    chk("t4_hold", hif.rdata, 32'hDEADBEEF);

    // Mid-frame base write does not disturb the current frame
    adv(704, 2);
    fb_base = 17'h04B00; fb_base_wr = 1'b1;
    adv(0, 2);
    fb_base_wr = 1'b0;
    @(negedge clk);
    chk("t5_cur2", 32'(mem_addr), 32'h240);
    adv(799, 2);
    adv(0, 3); @(negedge clk);
    chk("t5_cur3", 32'(mem_addr), 32'h2E0);
    adv(799, 524);
    fb_base = 17'h1FFF0; fb_base_wr = 1'b1;
    adv(0, 0);
    fb_base_wr = 1'b0;
    @(negedge clk);
    chk("t5_line0", 32'(mem_addr), 32'h4B00);
    adv(799, 0);
    adv(0, 1); @(negedge clk);
    chk("t5_line1", 32'(mem_addr), 32'h4BA0);

    // Base near the top of the address space wraps through zero
    adv(799, 524);
    adv(0, 0); @(negedge clk);
    chk("t6_line0", 32'(mem_addr), 32'h1FFF0);
    adv(64, 0); @(negedge clk);
    chk("t6_wrap", 32'(mem_addr), 32'h0);
    adv(65, 0);
    adv(66, 0); @(negedge clk);
    chk("t6_pix0", 32'(pix_data), 32'hA1);
    adv(67, 0); @(negedge clk);
    chk("t6_pix1", 32'(pix_data), 32'hA2);
    adv(799, 0);
    adv(0, 1); @(negedge clk);
    chk("t6_line1", 32'(mem_addr), 32'h90);

    // Sync and blank delay with arbitrary patterns
    for (int i = 0; i < 100; i++) begin
      adv(701, 2);
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      blank = 1'($urandom_range(0, 1));
      hs_q[i] = hsync; vs_q[i] = vsync; bl_q[i] = blank;
      @(negedge clk);
      if (i >= 2) begin
        chk("dly_hsync", 32'(pix_hsync), 32'(hs_q[i-2]));
        chk("dly_vsync", 32'(pix_vsync), 32'(vs_q[i-2]));
        chk("dly_blank", 32'(pix_blank), 32'(bl_q[i-2]));
        if (bl_q[i-2]) chk("dly_pixmask", 32'(pix_data), 32'd0);
      end
    end

    // Reset with a read outstanding drops the read
    adv(700, 2);
    hif.valid = 1'b1; hif.we = 1'b0; hif.addr = 17'h00010;
    adv(701, 2);
    hif.valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rr_rv0", 32'(hif.rvalid), 32'd0);
    adv(702, 2); @(negedge clk);
    chk("rr_rv1", 32'(hif.rvalid), 32'd0);
    chk("rr_rdata", hif.rdata, 32'd0);
    adv(703, 2);
    rst_n = 1'b1;
    adv(705, 2); @(negedge clk);
    chk("rr_rv2", 32'(hif.rvalid), 32'd0);
    adv(706, 2); @(negedge clk);
    chk("rr_rv3", 32'(hif.rvalid), 32'd0);
    chk("rr_rdata2", hif.rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
